uart_tx: RTL

//   Serial UART transmitter for the cpu_perefery peripheral set; the outbound

---
 rtl/uart_defs_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_defs_pkg.sv
// Shared UART definitions (state encodings, data width, default bit period); also used by myuart.
package uart_defs_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH; push visible to pop one cycle after the write edge.
// Backpressure: push while full and pop while empty are ignored with no state change.
module uart_tx_fifo
  import uart_defs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART 8N1/8E1 transmitter fed by a byte FIFO; start bit on the line 2 clks after a write to an idle unit.
// Backpressure: full=1 drops writes; queued frames go out back to back with no idle gap.
module uart_tx
  import uart_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   uart_out
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e            state, state_nxt;
  logic [BAUD_W-1:0]      baud_cnt, baud_nxt;
  logic [2:0]             bit_idx, bit_nxt;
  logic [UART_DATA_W-1:0] shift, shift_nxt;
  logic                   par_bit, par_nxt;
  logic                   bit_end;
  logic                   pop;
  logic                   empty;
  logic [UART_DATA_W-1:0] pop_dat;
  logic                   line_val;
  logic                   done_val;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .push_dat (wr_data),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (full),
    .empty    (empty)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? '0 : baud_cnt + BAUD_W'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    par_nxt   = par_bit;
    pop       = 1'b0;
    line_val  = 1'b1;
    done_val  = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = pop_dat;
          par_nxt   = even_parity(pop_dat);
          bit_nxt   = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        line_val = 1'b0;
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        line_val = shift[0];
        if (bit_end) begin
          shift_nxt = shift >> 1;
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        line_val = par_bit;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          done_val = 1'b1;
          // chain straight into the next start bit when more bytes are queued
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = pop_dat;
            par_nxt   = even_parity(pop_dat);
            bit_nxt   = '0;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      uart_out <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_nxt;
      uart_out <= line_val;
      tx_done  <= done_val;
    end
  end

  assign busy = (state != ST_IDLE) || !empty;

endmodule
